// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use, branch-in-ID and mult/div interlocks,
// squash control for taken branches, mult/div busy tracking and a stall counter.
module hazard_ctrl #(
   parameter int unsigned MD_LAT = 8
) (
   input  logic        CLK,
   input  logic        RST_N,
   input  logic [4:0]  ID_RS,
   input  logic [4:0]  ID_RT,
   input  logic        ID_UsesRS,
   input  logic        ID_UsesRT,
   input  logic        ID_Branch,
   input  logic        ID_MulDiv,
   input  logic        ID_ReadsHILO,
   input  logic        BranchTaken,
   input  logic [4:0]  EX_WriteReg,
   input  logic        EX_RegWrite,
   input  logic        EX_MemtoReg,
   input  logic [4:0]  EX_MEM_WriteReg,
   input  logic        EX_MEM_RegWrite,
   input  logic        EX_MEM_MemtoReg,
   output logic        PC_Stall,
   output logic        IF_ID_Stall,
   output logic        ID_EX_Bubble,
   output logic        IF_ID_Flush,
   output logic        MD_Start,
   output logic        MD_Busy,
   output logic [15:0] STALL_CNT
);

   typedef enum logic [0:0] {
      MD_IDLE,
      MD_BUSY
   } mdState_t;

   localparam logic [4:0] MdLoad = 5'(MD_LAT);

   logic [4:0]  mdCnt;
   logic [15:0] stallCnt;
   mdState_t    mdState;

   logic        loadUseHaz;
   logic        branchHaz;
   logic        mdHaz;
   logic        stallRaw;
   logic        mdStartRaw;
   logic        memLoadWe;

   // Register 0 is hardwired, so a write to it never creates a dependency.
   function automatic logic regMatch(input logic [4:0] src, input logic [4:0] dst,
                                     input logic we);
      return (src == dst) && we && (dst != 5'd0);
   endfunction

   always_comb begin
      mdState    = (mdCnt != '0) ? MD_BUSY : MD_IDLE;
      memLoadWe  = EX_MEM_RegWrite && EX_MEM_MemtoReg;

      loadUseHaz = EX_MemtoReg &&
                   ((ID_UsesRS && regMatch(ID_RS, EX_WriteReg, EX_RegWrite)) ||
                    (ID_UsesRT && regMatch(ID_RT, EX_WriteReg, EX_RegWrite)));

      branchHaz  = ID_Branch &&
                   ((ID_UsesRS && (regMatch(ID_RS, EX_WriteReg, EX_RegWrite) ||
                                   regMatch(ID_RS, EX_MEM_WriteReg, memLoadWe))) ||
                    (ID_UsesRT && (regMatch(ID_RT, EX_WriteReg, EX_RegWrite) ||
                                   regMatch(ID_RT, EX_MEM_WriteReg, memLoadWe))));

      mdHaz      = (mdState == MD_BUSY) && (ID_MulDiv || ID_ReadsHILO);
      stallRaw   = loadUseHaz || branchHaz || mdHaz;
      mdStartRaw = ID_MulDiv && !stallRaw;
   end

   // Combinational outputs are qualified by reset so they read 0 while it is held.
   assign PC_Stall     = RST_N && stallRaw;
   assign IF_ID_Stall  = RST_N && stallRaw;
   assign ID_EX_Bubble = RST_N && stallRaw;
   assign IF_ID_Flush  = RST_N && BranchTaken && !stallRaw;
   assign MD_Start     = RST_N && mdStartRaw;
   assign MD_Busy      = (mdState == MD_BUSY);
   assign STALL_CNT    = stallCnt;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         mdCnt    <= '0;
         stallCnt <= '0;
      end else begin
         if (mdStartRaw) begin
            mdCnt <= MdLoad;
         end else begin
            case (mdState)
               MD_BUSY: mdCnt <= mdCnt - 5'd1;
               default: mdCnt <= mdCnt;
            endcase
         end

         if (stallRaw && (stallCnt != '1)) begin
            stallCnt <= stallCnt + 16'd1;
         end
      end
   end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: cycle-level reference model plus directed
// scenarios (load-use, r0, branch, mult/div timing, async reset, counter saturation).
module tb_hazard_ctrl;

   localparam int unsigned LAT = 8;

   logic        CLK = 1'b0;
   logic        RST_N;
   logic [4:0]  ID_RS, ID_RT;
   logic        ID_UsesRS, ID_UsesRT, ID_Branch, ID_MulDiv, ID_ReadsHILO, BranchTaken;
   logic [4:0]  EX_WriteReg;
   logic        EX_RegWrite, EX_MemtoReg;
   logic [4:0]  EX_MEM_WriteReg;
   logic        EX_MEM_RegWrite, EX_MEM_MemtoReg;
   logic        PC_Stall, IF_ID_Stall, ID_EX_Bubble, IF_ID_Flush, MD_Start, MD_Busy;
   logic [15:0] STALL_CNT;

   hazard_ctrl #(.MD_LAT(LAT)) dut (
      .CLK(CLK), .RST_N(RST_N),
      .ID_RS(ID_RS), .ID_RT(ID_RT),
      .ID_UsesRS(ID_UsesRS), .ID_UsesRT(ID_UsesRT),
      .ID_Branch(ID_Branch), .ID_MulDiv(ID_MulDiv), .ID_ReadsHILO(ID_ReadsHILO),
      .BranchTaken(BranchTaken),
      .EX_WriteReg(EX_WriteReg), .EX_RegWrite(EX_RegWrite), .EX_MemtoReg(EX_MemtoReg),
      .EX_MEM_WriteReg(EX_MEM_WriteReg), .EX_MEM_RegWrite(EX_MEM_RegWrite),
      .EX_MEM_MemtoReg(EX_MEM_MemtoReg),
      .PC_Stall(PC_Stall), .IF_ID_Stall(IF_ID_Stall), .ID_EX_Bubble(ID_EX_Bubble),
      .IF_ID_Flush(IF_ID_Flush), .MD_Start(MD_Start), .MD_Busy(MD_Busy),
      .STALL_CNT(STALL_CNT)
   );

   always #5 CLK = ~CLK;

   int tests = 0;
   int fails = 0;

   task automatic chk(input string name, input longint act, input longint exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: time is counted in cycles since reset; the unit is busy
   // for the LAT cycles following the cycle an op was accepted.
   int     cycleNo   = 0;
   int     lastIssue = -1;
   longint stallTotal = 0;

   function automatic bit hits(input logic [4:0] src, input logic uses,
                               input logic [4:0] dst, input logic we);
      return uses && we && (dst != 5'd0) && (src == dst);
   endfunction

   always @(negedge CLK) begin
      bit         busy, lu, br, md, st;
      int         age;
      logic [4:0] src [2];
      logic       usesSrc [2];
      longint     expCnt;
      if (!RST_N) begin
         chk("rst_PC_Stall", PC_Stall, 0);
         chk("rst_IF_ID_Stall", IF_ID_Stall, 0);
         chk("rst_ID_EX_Bubble", ID_EX_Bubble, 0);
         chk("rst_IF_ID_Flush", IF_ID_Flush, 0);
         chk("rst_MD_Start", MD_Start, 0);
         chk("rst_MD_Busy", MD_Busy, 0);
         chk("rst_STALL_CNT", STALL_CNT, 0);
         cycleNo    = 0;
         lastIssue  = -1;
         stallTotal = 0;
      end else begin
         age  = cycleNo - lastIssue;
         busy = (lastIssue >= 0) && (age >= 1) && (age <= int'(LAT));
         src[0] = ID_RS;  usesSrc[0] = ID_UsesRS;
         src[1] = ID_RT;  usesSrc[1] = ID_UsesRT;
         lu = 0;
         br = 0;
         for (int i = 0; i < 2; i++) begin
            if (EX_MemtoReg && hits(src[i], usesSrc[i], EX_WriteReg, EX_RegWrite)) lu = 1;
            if (ID_Branch && (hits(src[i], usesSrc[i], EX_WriteReg, EX_RegWrite) ||
                hits(src[i], usesSrc[i], EX_MEM_WriteReg, EX_MEM_RegWrite && EX_MEM_MemtoReg)))
               br = 1;
         end
         md = busy && (ID_MulDiv || ID_ReadsHILO);
         st = lu || br || md;
         expCnt = (stallTotal > 65535) ? 65535 : stallTotal;

         chk("m_PC_Stall", PC_Stall, st);
         chk("m_IF_ID_Stall", IF_ID_Stall, st);
         chk("m_ID_EX_Bubble", ID_EX_Bubble, st);
         chk("m_IF_ID_Flush", IF_ID_Flush, BranchTaken && !st);
         chk("m_MD_Start", MD_Start, ID_MulDiv && !st);
         chk("m_MD_Busy", MD_Busy, busy);
         chk("m_STALL_CNT", STALL_CNT, expCnt);

         if (ID_MulDiv && !st) lastIssue = cycleNo;
         if (st) stallTotal++;
         cycleNo++;
      end
   end

   task automatic setIdle();
      ID_RS = '0; ID_RT = '0; ID_UsesRS = 0; ID_UsesRT = 0;
      ID_Branch = 0; ID_MulDiv = 0; ID_ReadsHILO = 0; BranchTaken = 0;
      EX_WriteReg = '0; EX_RegWrite = 0; EX_MemtoReg = 0;
      EX_MEM_WriteReg = '0; EX_MEM_RegWrite = 0; EX_MEM_MemtoReg = 0;
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic setLoadUse();
      setIdle();
      EX_WriteReg = 5'd5; EX_RegWrite = 1; EX_MemtoReg = 1;
      ID_RS = 5'd5; ID_UsesRS = 1;
   endtask

   initial begin
      RST_N = 0;
      setIdle();
      repeat (3) step();
      chk("reset_STALL_CNT", STALL_CNT, 0);
      chk("reset_MD_Busy", MD_Busy, 0);
      // Hazard-provoking inputs must not leak through while reset is held.
      setLoadUse();
      ID_MulDiv = 1; BranchTaken = 1;
      #1;
      chk("reset_forced_stall", PC_Stall, 0);
      chk("reset_forced_flush", IF_ID_Flush, 0);
      chk("reset_forced_start", MD_Start, 0);
      setIdle();
      RST_N = 1;

      // Load-use on $5: one stall, then released once the load moves to MEM.
      step();
      setLoadUse();
      #1;
      chk("lu_stall", PC_Stall, 1);
      chk("lu_bubble", ID_EX_Bubble, 1);
      chk("lu_cnt0", STALL_CNT, 0);
      step();
      EX_WriteReg = '0; EX_RegWrite = 0; EX_MemtoReg = 0;
      EX_MEM_WriteReg = 5'd5; EX_MEM_RegWrite = 1; EX_MEM_MemtoReg = 1;
      #1;
      chk("lu_release", PC_Stall, 0);
      chk("lu_cnt1", STALL_CNT, 1);

      // Writes to $0 never interlock.
      step();
      setIdle();
      EX_WriteReg = 5'd0; EX_RegWrite = 1; EX_MemtoReg = 1;
      ID_RS = 5'd0; ID_UsesRS = 1; ID_RT = 5'd0; ID_UsesRT = 1;
      #1;
      chk("r0_nostall", PC_Stall, 0);

      // Branch on $3 with producer in EX: stall, no flush; then flush.
      step();
      setIdle();
      ID_Branch = 1; ID_RS = 5'd3; ID_UsesRS = 1; BranchTaken = 1;
      EX_WriteReg = 5'd3; EX_RegWrite = 1;
      #1;
      chk("br_stall", PC_Stall, 1);
      chk("br_noflush", IF_ID_Flush, 0);
      step();
      EX_WriteReg = '0; EX_RegWrite = 0;
      EX_MEM_WriteReg = 5'd3; EX_MEM_RegWrite = 1; EX_MEM_MemtoReg = 0;
      #1;
      chk("br_go", PC_Stall, 0);
      chk("br_flush", IF_ID_Flush, 1);
      EX_MEM_MemtoReg = 1;
      #1;
      chk("br_memload_stall", PC_Stall, 1);

      // Mult issue, mfhi stalls LAT cycles and proceeds on the next one.
      step();
      setIdle();
      ID_MulDiv = 1;
      #1;
      chk("md_start", MD_Start, 1);
      chk("md_notbusy", MD_Busy, 0);
      step();
      ID_MulDiv = 0; ID_ReadsHILO = 1;
      for (int k = 0; k < int'(LAT); k++) begin
         #1;
         chk("mfhi_busy", MD_Busy, 1);
         chk("mfhi_stall", PC_Stall, 1);
         step();
      end
      #1;
      chk("mfhi_idle", MD_Busy, 0);
      chk("mfhi_go", PC_Stall, 0);

      // Back-to-back mult: second waits through the final busy cycle.
      ID_ReadsHILO = 0; ID_MulDiv = 1;
      #1;
      chk("md2_start", MD_Start, 1);
      step();
      for (int k = 0; k < int'(LAT); k++) begin
         #1;
         chk("md2_held", MD_Start, 0);
         step();
      end
      #1;
      chk("md2_issue", MD_Start, 1);
      step();
      setIdle();
      repeat (LAT + 1) step();

      // Async reset mid-operation at 4 cycles remaining.
      ID_MulDiv = 1;
      #1;
      chk("rst_md_start", MD_Start, 1);
      step();
      ID_MulDiv = 0; ID_ReadsHILO = 1;
      repeat (4) step();
      setLoadUse();
      ID_ReadsHILO = 1; ID_MulDiv = 1; BranchTaken = 1;
      #1;
      chk("pre_rst_busy", MD_Busy, 1);
      chk("pre_rst_stall", PC_Stall, 1);
      RST_N = 0;
      #1;
      chk("async_busy", MD_Busy, 0);
      chk("async_cnt", STALL_CNT, 0);
      chk("async_stall", PC_Stall, 0);
      chk("async_ifid", IF_ID_Stall, 0);
      chk("async_bubble", ID_EX_Bubble, 0);
      chk("async_flush", IF_ID_Flush, 0);
      chk("async_start", MD_Start, 0);
      step();
      setIdle();
      RST_N = 1;

      // Randomized traffic with occasional one-cycle resets.
      for (int n = 0; n < 3000; n++) begin
         step();
         RST_N           = ($urandom_range(0, 499) != 0);
         ID_RS           = 5'($urandom_range(0, 3));
         ID_RT           = 5'($urandom_range(0, 3));
         ID_UsesRS       = ($urandom_range(0, 9) < 7);
         ID_UsesRT       = ($urandom_range(0, 9) < 5);
         ID_Branch       = ($urandom_range(0, 3) == 0);
         BranchTaken     = ID_Branch && $urandom_range(0, 1);
         ID_MulDiv       = ($urandom_range(0, 9) < 2);
         ID_ReadsHILO    = ($urandom_range(0, 9) < 2);
         EX_WriteReg     = 5'($urandom_range(0, 3));
         EX_RegWrite     = ($urandom_range(0, 9) < 7);
         EX_MemtoReg     = ($urandom_range(0, 9) < 4);
         EX_MEM_WriteReg = 5'($urandom_range(0, 3));
         EX_MEM_RegWrite = ($urandom_range(0, 9) < 7);
         EX_MEM_MemtoReg = ($urandom_range(0, 9) < 4);
      end

      // Counter saturation after 65540 consecutive stalls.
      step();
      setIdle();
      RST_N = 0;
      step();
      RST_N = 1;
      setLoadUse();
      repeat (65540) step();
      chk("sat_cnt", STALL_CNT, 16'hFFFF);
      chk("sat_stall", PC_Stall, 1);
      setIdle();
      step();
      chk("sat_hold", STALL_CNT, 16'hFFFF);
      step();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
